// File: rtl/div_stg_if.sv
// Start/done handshake and operand/result bundle for the staged divider.
// The master drives the operands and the divider (slave) returns the results.
interface div_stg_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/div_stg.sv
// Sequential unsigned restoring divider that produces one quotient bit per clock.
// It uses the same start/done handshake as the staged multiplier.
module div_stg #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  div_stg_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic [WIDTH:0]   rem_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             dbz_reg;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;
  logic             zero_div;

  // The trial difference carries one extra bit so its MSB is a clean borrow.
  always_comb begin
    shifted   = {rem_reg, q_reg[WIDTH-1]};
    trial     = shifted - {2'b00, dsr_reg};
    rem_next  = shifted[WIDTH:0];
    q_next    = {q_reg[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH+1]) begin
      rem_next = trial[WIDTH:0];
      q_next   = {q_reg[WIDTH-2:0], 1'b1};
    end
    last_iter = (cnt == CW'(WIDTH - 1));
    zero_div  = (bus.divisor == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = zero_div ? DONE : CALC;
      CALC: if (last_iter) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The result registers load only on entry to DONE, so the ports hold steady through CALC and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg         <= '0;
      dsr_reg       <= '0;
      rem_reg       <= '0;
      cnt           <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            q_reg   <= bus.dividend;
            dsr_reg <= bus.divisor;
            rem_reg <= '0;
            cnt     <= '0;
            dbz_reg <= 1'b0;
            if (zero_div) begin
              quotient_reg  <= '1;
              remainder_reg <= bus.dividend;
              dbz_reg       <= 1'b1;
            end
          end
        end
        CALC: begin
          q_reg   <= q_next;
          rem_reg <= rem_next;
          cnt     <= cnt + CW'(1);
          if (last_iter) begin
            quotient_reg  <= q_next;
            remainder_reg <= rem_next[WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.busy        = (state == CALC);
  assign bus.done        = (state == DONE);

endmodule

// File: tb/tb_div_stg.sv
// Scoreboard bench for div_stg: the stimulus pushes expected results computed with plain arithmetic.
// A negedge monitor pops and compares them whenever done is high.
module tb_div_stg;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_stg_if #(.WIDTH(WIDTH)) bus();

  div_stg #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int dbz;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   busy_begin  = 0;
  int   busy_end    = 0;
  bit   running     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic exp_t refModel(input int a, input int b, input int done_cyc);
    exp_t e;
    if (b == 0) begin
      e.q   = (1 << WIDTH) - 1;
      e.r   = a;
      e.dbz = 1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 0;
    end
    e.cyc = done_cyc;
    return e;
  endfunction

  // Issue one division and then wait out the minimum start-to-start interval plus an optional gap.
  task automatic applyStimulus(input int a, input int b, input int gap);
    int n;
    bus.dividend = WIDTH'(a);
    bus.divisor  = WIDTH'(b);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    n         = cyc;
    bus.start = 1'b0;
    sb.push_back(refModel(a, b, (b == 0) ? n : n + WIDTH));
    if (b != 0) begin
      busy_begin = n;
      busy_end   = n + WIDTH;
    end
    repeat (((b == 0) ? 1 : WIDTH + 1) + gap) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (running) begin
      checkOutput("busy", int'(bus.busy), int'(cyc >= busy_begin && cyc < busy_end));
      checkOutput("busy_done_overlap", int'(bus.busy && bus.done), 0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_done", int'(bus.done), 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("quotient", int'(bus.quotient), mon_e.q);
          checkOutput("remainder", int'(bus.remainder), mon_e.r);
          checkOutput("div_by_zero", int'(bus.div_by_zero), mon_e.dbz);
          checkOutput("done_cycle", cyc, mon_e.cyc);
        end
      end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
        checkOutput("done_missing", int'(bus.done), 1);
        mon_e = sb.pop_front();
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d results pending", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int t;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_quotient", int'(bus.quotient), 0);
    checkOutput("reset_remainder", int'(bus.remainder), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_dbz", int'(bus.div_by_zero), 0);
    running = 1'b1;
    @(posedge clk); #1;

    applyStimulus(13, 3, 1);
    applyStimulus(15, 1, 0);
    applyStimulus(3, 7, 0);
    applyStimulus(5, 0, 0);
    applyStimulus(9, 2, 2);

    // A start pulse with new operands during CALC must be neither queued nor latched.
    bus.dividend = 4'd12;
    bus.divisor  = 4'd5;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    n          = cyc;
    bus.start  = 1'b0;
    sb.push_back(refModel(12, 5, n + WIDTH));
    busy_begin = n;
    busy_end   = n + WIDTH;
    @(posedge clk); #1;
    bus.dividend = 4'd1;
    bus.divisor  = 4'd1;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (WIDTH - 1) begin
      @(posedge clk); #1;
    end

    // Reset two edges into a division abandons it without any done.
    bus.dividend = 4'd14;
    bus.divisor  = 4'd3;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    n          = cyc;
    bus.start  = 1'b0;
    busy_begin = n;
    busy_end   = n + 2;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_quotient", int'(bus.quotient), 0);
    checkOutput("abort_remainder", int'(bus.remainder), 0);
    checkOutput("abort_dbz", int'(bus.div_by_zero), 0);
    checkOutput("abort_done", int'(bus.done), 0);
    repeat (WIDTH) begin
      @(posedge clk); #1;
    end

    // Reset and start on the same edge: the start is dropped.
    bus.dividend = 4'd7;
    bus.divisor  = 4'd1;
    bus.start    = 1'b1;
    rst          = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (WIDTH + 3) begin
      @(posedge clk); #1;
    end

    applyStimulus(14, 3, 0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)));
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(a, b, 0);
      end
    end

    t = 0;
    while (sb.size() > 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("scoreboard_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_stg.md
# div_stg

Sequential unsigned restoring divider. It is the inverse companion to the team's staged multiplier: it takes a WIDTH-bit dividend and divisor and produces a WIDTH-bit quotient and remainder, one quotient bit per clock. Its start/done handshake matches the multiplier stage, so the two can share a bench and an exhaustive operand sweep (a*b / b == a).

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  request a division; sampled on rising clk
- dividend  input  WIDTH  numerator, unsigned
- divisor  input  WIDTH  denominator, unsigned
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse: results valid
- div_by_zero  output  1  high with done when divisor was 0; held until next accepted start

## Operation
- States: IDLE, CALC, DONE.
- IDLE, start=1:
  - latch dividend and divisor;
  - clear the partial remainder (WIDTH+1 bits) and the iteration counter (clog2(WIDTH+1) bits);
  - clear div_by_zero;
  - go to CALC. If divisor==0, go to DONE instead (see below).
- IDLE, start=0: stay in IDLE.
- CALC, each cycle:
  - shift {rem, q} left 1, bringing the next dividend MSB into the rem LSB;
  - trial = rem − divisor (WIDTH+1-bit);
  - if trial ≥ 0, rem = trial and q LSB = 1, else q LSB = 0;
  - counter++. After WIDTH iterations go to DONE.
- DONE:
  - done=1 for exactly one cycle;
  - quotient and remainder drive the final values;
  - next state is IDLE unconditionally.
- Divide by zero:
  - start with divisor==0 → DONE on the next edge;
  - quotient = all ones, remainder = dividend, div_by_zero=1;
  - no CALC cycles.
- start while in CALC or DONE is ignored. It is not queued, and the operands are not re-latched.
- Outputs quotient, remainder and div_by_zero hold their last values through IDLE until the next accepted start. Internal working registers may change during CALC, but the output ports update only on entry to DONE.
- Widths: no overflow is possible. Quotient ≤ dividend and remainder < divisor. The invariant is dividend == quotient*divisor + remainder whenever div_by_zero=0.

## Timing
- Reset (rst=1 on a rising edge):
  - state=IDLE;
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0;
  - counter cleared.
  - rst has priority over start and over any in-progress operation. A division interrupted mid-CALC is abandoned and never produces done.
- Accept: start=1 at edge N in IDLE.
  - busy=1 from after edge N through edge N+WIDTH.
  - The final iteration occurs at edge N+WIDTH, and the state enters DONE.
  - done=1 and results valid during the cycle after edge N+WIDTH.
  - Edge N+WIDTH+1 returns to IDLE with done=0.
  - The next start is accepted at edge N+WIDTH+2 at the earliest.
- Latency: WIDTH+1 cycles from start to done. The start-to-start interval is WIDTH+2 cycles.
- Divide by zero: start at edge N → done=1 during the cycle after edge N, busy never asserted → IDLE at edge N+1.
- busy and done are never high together. done is low in IDLE and CALC.
- rst=1 and start=1 on the same edge: reset wins and start is dropped.

## Test plan
- Reset, then start with dividend=13, divisor=3 (WIDTH=4) → busy for 4 cycles; done at edge N+4 with quotient=4, remainder=1, div_by_zero=0.
- dividend=15, divisor=1 → quotient=15, remainder=0. Also dividend=3, divisor=7 → quotient=0, remainder=3.
- dividend=5, divisor=0 → done one cycle after start, busy stays 0; quotient=15, remainder=5, div_by_zero=1. A following 9/2 clears div_by_zero and yields 4 r 1.
- Start 12/5, pulse start with 1/1 during CALC → ignored; result 2 r 2, and exactly one done pulse.
- Start 14/3, assert rst at edge N+2 → all outputs 0 and IDLE next cycle, no done. A new 14/3 then gives 4 r 2.
- Exhaustive sweep over all 16×16 pairs with back-to-back starts at the minimum interval → every result satisfies dividend == q*d + r with r < d, or the divide-by-zero convention when d=0.
